// File: rtl/mtsp_gscs_counter.sv
// mtsp_gscs_counter: four X/Y/Z/W scratch coordinate counters with programmable wrap limits
// and optional carry chaining X->Y->Z->W; lane i occupies bits [i*CW +: CW] of each bus.
module mtsp_gscs_counter #(
    parameter int CW = 8
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            EN,
    input  logic [3:0]      GSCs_RST,
    input  logic [3:0]      GSCs_INC,
    input  logic [3:0]      CHAIN,
    input  logic [3:0]      LIMIT_WE,
    input  logic [4*CW-1:0] LIMIT_DATA,
    output logic [4*CW-1:0] GSCs,
    output logic [3:0]      GSCs_WRAP
);
    logic [3:0][CW-1:0] cnt, lim, base, nxt, limit_data;
    logic [3:0] inc, wrap, wrap_q;
    logic carry;

    assign limit_data = LIMIT_DATA;
    assign GSCs       = cnt;
    assign GSCs_WRAP  = wrap_q;

    // carry ripples lane to lane within the cycle; lane X never sees one
    always_comb begin
        carry = 1'b0;
        for (int i = 0; i < 4; i++) begin
            base[i] = GSCs_RST[i] ? '0 : cnt[i];
            inc[i]  = GSCs_INC[i] | (CHAIN[i] & carry);
            wrap[i] = inc[i] & (base[i] >= lim[i]);
            nxt[i]  = !inc[i] ? base[i] : (wrap[i] ? '0 : base[i] + CW'(1));
            carry   = wrap[i];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt    <= '0;
            lim    <= '1;
            wrap_q <= '0;
        end else begin
            if (EN) cnt <= nxt;
            wrap_q <= EN ? wrap : 4'b0;
            for (int i = 0; i < 4; i++)
                if (LIMIT_WE[i]) lim[i] <= limit_data[i];
        end
    end
endmodule

// File: tb/tb_mtsp_gscs_counter.sv
// tb_mtsp_gscs_counter: directed scenarios plus randomized traffic against an arithmetic
// reference model of the coordinate counters.
module tb_mtsp_gscs_counter;
    localparam int CW = 8;

    logic            CLK = 1'b0;
    logic            nRST = 1'b0;
    logic            EN = 1'b0;
    logic [3:0]      GSCs_RST = '0, GSCs_INC = '0, CHAIN = '0, LIMIT_WE = '0;
    logic [4*CW-1:0] LIMIT_DATA = '0;
    logic [4*CW-1:0] GSCs;
    logic [3:0]      GSCs_WRAP;

    int checks = 0, errors = 0;
    int m_cnt[4], m_lim[4];
    logic [3:0] m_wrap;

    mtsp_gscs_counter #(.CW(CW)) dut (
        .CLK(CLK), .nRST(nRST), .EN(EN), .GSCs_RST(GSCs_RST), .GSCs_INC(GSCs_INC),
        .CHAIN(CHAIN), .LIMIT_WE(LIMIT_WE), .LIMIT_DATA(LIMIT_DATA),
        .GSCs(GSCs), .GSCs_WRAP(GSCs_WRAP)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            m_lim[i] = 255;
        end
        m_wrap = '0;
    endfunction

    function automatic logic [31:0] model_gscs();
        logic [31:0] v = '0;
        for (int i = 0; i < 4; i++) v |= 32'(m_cnt[i]) << (i * CW);
        return v;
    endfunction

    function automatic int lane(input int l);
        return int'(GSCs[l*CW +: CW]);
    endfunction

    // advance the model by the rules, clock the DUT once and compare both outputs
    task automatic step();
        bit carry = 0;
        logic [3:0] w = '0;
        int base;
        bit inc;
        if (EN) begin
            for (int i = 0; i < 4; i++) begin
                base = GSCs_RST[i] ? 0 : m_cnt[i];
                inc = GSCs_INC[i] || (i > 0 && CHAIN[i] && carry);
                w[i] = inc && base >= m_lim[i];
                m_cnt[i] = !inc ? base : (w[i] ? 0 : base + 1);
                carry = w[i];
            end
        end
        m_wrap = w;
        for (int i = 0; i < 4; i++)
            if (LIMIT_WE[i]) m_lim[i] = int'(LIMIT_DATA[i*CW +: CW]);
        @(posedge CLK);
        #1;
        check("gscs", GSCs, model_gscs());
        check("wrap", 32'(GSCs_WRAP), 32'(m_wrap));
        @(negedge CLK);
    endtask

    task automatic async_reset();
        @(posedge CLK);
        #3;
        nRST = 1'b0;
        #1;
        check("async_gscs", GSCs, 32'd0);
        check("async_wrap", 32'(GSCs_WRAP), 32'd0);
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    int x_exp2[4] = '{1, 2, 3, 0};
    int x_exp3[6] = '{1, 0, 1, 0, 1, 0};
    int y_exp3[6] = '{0, 1, 1, 2, 2, 0};

    initial begin
        model_reset();
        repeat (2) @(negedge CLK);
        check("reset_gscs", GSCs, 32'd0);
        check("reset_wrap", 32'(GSCs_WRAP), 32'd0);
        nRST = 1'b1;
        // 1: limit resets to 255, so ten increments reach 10
        EN = 1'b1;
        GSCs_INC = 4'b0001;
        repeat (10) step();
        check("t1_x10", 32'(lane(0)), 32'd10);
        async_reset();
        // 2: wrap at 3
        GSCs_INC = '0;
        EN = 1'b0;
        LIMIT_WE = 4'b0001;
        LIMIT_DATA = 32'h0000_0003;
        step();
        LIMIT_WE = '0;
        EN = 1'b1;
        GSCs_INC = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t2_x", 32'(lane(0)), 32'(x_exp2[k]));
            check("t2_wrapx", 32'(GSCs_WRAP[0]), 32'(k == 3));
        end
        // 3: chain X into Y
        GSCs_INC = '0;
        EN = 1'b0;
        LIMIT_WE = 4'b0011;
        LIMIT_DATA = 32'h0000_0201;
        step();
        LIMIT_WE = '0;
        EN = 1'b1;
        CHAIN = 4'b0010;
        GSCs_INC = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            step();
            check("t3_x", 32'(lane(0)), 32'(x_exp3[k]));
            check("t3_y", 32'(lane(1)), 32'(y_exp3[k]));
            check("t3_wrapy", 32'(GSCs_WRAP[1]), 32'(k == 5));
        end
        // 4: simultaneous RST+INC, then held strobes dropped
        CHAIN = '0;
        GSCs_INC = 4'b0100;
        repeat (5) step();
        check("t4_z5", 32'(lane(2)), 32'd5);
        GSCs_RST = 4'b0100;
        step();
        GSCs_RST = '0;
        check("t4_z1", 32'(lane(2)), 32'd1);
        EN = 1'b0;
        repeat (3) begin
            step();
            check("t4_hold_z", 32'(lane(2)), 32'd1);
            check("t4_hold_wrap", 32'(GSCs_WRAP), 32'd0);
        end
        // 5: lowered limit uses the old limit on the writing edge
        EN = 1'b1;
        GSCs_INC = 4'b1000;
        repeat (10) step();
        LIMIT_WE = 4'b1000;
        LIMIT_DATA = 32'h0400_0000;
        step();
        LIMIT_WE = '0;
        check("t5_w11", 32'(lane(3)), 32'd11);
        step();
        check("t5_w0", 32'(lane(3)), 32'd0);
        check("t5_wrapw", 32'(GSCs_WRAP[3]), 32'd1);
        // 6: full cascade at limit 0
        GSCs_INC = '0;
        LIMIT_WE = 4'hf;
        LIMIT_DATA = '0;
        step();
        LIMIT_WE = '0;
        CHAIN = 4'hf;
        GSCs_INC = 4'b0001;
        step();
        check("t6_gscs", GSCs, 32'd0);
        check("t6_wrap", 32'(GSCs_WRAP), 32'hf);
        GSCs_INC = '0;
        step();
        check("t6_wrap_clr", 32'(GSCs_WRAP), 32'd0);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            EN = ($urandom % 4) != 0;
            GSCs_INC = 4'($urandom);
            CHAIN = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                GSCs_RST[i] = ($urandom % 8) == 0;
                LIMIT_WE[i] = ($urandom % 16) == 0;
                LIMIT_DATA[i*CW +: CW] = ($urandom % 10 == 0) ? 8'hff : 8'($urandom_range(0, 7));
            end
            step();
            if (n % 700 == 699) async_reset();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mtsp_gscs_counter.md
# mtsp_gscs_counter

Per-lane scratch coordinate counters (GSCs) for the MTSP core. The block consumes the per-lane reset/increment strobes produced by the scratch-coordinate decoder stage and holds the four X/Y/Z/W scratch coordinates used for scratch-memory addressing. Each lane has a programmable wrap limit and optional carry chaining into the next lane. It sits directly downstream of the decoder and upstream of scratch address generation.

## Interface

- CW, default 8: counter and limit width per lane.
- Reset is asynchronous and active-low, on a single clock.
- Lane order in every 4-bit and 4×CW bus follows the `RANGE_MASK4D_{X,Y,Z,W}` field positions.
- Chain order is X→Y→Z→W.

Ports (name, direction, width, meaning):

- CLK  in  1  core clock.
- nRST  in  1  asynchronous active-low reset.
- EN  in  1  pipeline advance. When 0, counters hold and GSCs_RST/GSCs_INC are ignored.
- GSCs_RST  in  4  per-lane counter reset strobe, sampled when EN=1.
- GSCs_INC  in  4  per-lane counter increment strobe, sampled when EN=1.
- CHAIN  in  4  per-lane carry enable. A lane increments when its lower neighbour wraps. CHAIN[X] is ignored.
- LIMIT_WE  in  4  per-lane limit write enable. Independent of EN.
- LIMIT_DATA  in  4×CW  new limit values.
- GSCs  out  4×CW  current counter values (registered).
- GSCs_WRAP  out  4  per-lane wrap pulse (registered).

## Operation

**Per-lane registers**
- CNT[i] (CW bits), reset value 0.
- LIM[i] (CW bits), reset value all ones.
- WRAP[i], reset value 0.

**Effective increment**
- inc[X] = GSCs_INC[X].
- inc[k] = GSCs_INC[k] | (CHAIN[k] & wrap[k-1]).
- The carry ripples combinationally in the same cycle, so X→Y→Z→W can all wrap on one edge.
- INC and carry arriving together add 1, not 2.

**Next-value computation**, evaluated only when EN=1:
- base = GSCs_RST[i] ? 0 : CNT[i].
- wrap[i] = inc[i] & (base >= LIM[i]).
- next = !inc[i] ? base : (wrap[i] ? 0 : base+1).
- Simultaneous RST and INC therefore gives 1, or 0 with a wrap when LIM=0.
- The `>=` compare means a counter left above a newly lowered limit wraps on its next increment.

**Hold and limit writes**
- EN=0: CNT holds and WRAP is 0 on the next cycle.
- LIMIT_WE[i]=1: LIM[i] <= LIMIT_DATA lane i on the edge. The compare on that same edge uses the old LIM.
- No arithmetic overflow can occur, because the maximum LIM is all ones and the counter wraps there.

## Timing

- All outputs are registered.
- GSCs shows the updated value in the cycle after the sampling edge (1-cycle latency).
- GSCs_WRAP[i] is high for exactly one cycle following an edge where wrap[i]=1 and EN=1.
- Asynchronous reset mid-operation clears CNT and WRAP and sets LIM to all ones immediately, without waiting for CLK.
- After nRST deasserts, the first sampling edge behaves as normal operation.
- EN=0 for any number of cycles loses no state. Strobes presented while EN=0 are dropped, not queued.
- Back-to-back INC on consecutive EN=1 cycles increments every cycle. There is no bubble.

## Test plan

1. **Reset:** assert nRST=0 between clock edges. GSCs goes to 0 and GSCs_WRAP to 0 at once. After release, INC X ten times gives X=10, confirming the limit reset to 255.
2. **Wrap:** write LIM X=3, then INC X on 4 consecutive cycles. GSCs X reads 1, 2, 3, 0, and GSCs_WRAP[X] pulses only with the 0.
3. **Chain:** LIM X=1, LIM Y=2, CHAIN[Y]=1, INC X on 6 consecutive cycles.
   - X reads 1, 0, 1, 0, 1, 0.
   - Y reads 0, 1, 1, 2, 2, 0.
   - WRAP[Y] pulses on the 6th update, together with WRAP[X].
4. **Simultaneous strobes and hold:** with Z=5, assert RST and INC on Z together: Z becomes 1. Then hold EN=0 and pulse INC Z for 3 cycles: Z stays 1 and no WRAP pulses.
5. **Lowered limit:** with W=10, write LIM W=4 in the same cycle as INC W. W becomes 11, because the old limit of 255 is used. The next INC W gives 0 with a WRAP[W] pulse.
6. **Full cascade:** all limits 0, CHAIN=4'b1111, one INC X. All lanes stay 0 and GSCs_WRAP=4'b1111 for one cycle.
